// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the core's inter-stage registers: stall encoding,
// stage indices, payload widths, NOP payloads and the per-edge action decode.
package pipe_stage_reg_pkg;

    localparam logic STOP       = 1'b1;
    localparam logic NO_STOP    = 1'b0;
    localparam logic RST_ENABLE = 1'b1;

    localparam int STALL_VEC_W = 6;

    // Bit 0 of the stall vector belongs to the PC; each register owns the next bit up.
    localparam int STAGE_IF_ID  = 1;
    localparam int STAGE_ID_EX  = 2;
    localparam int STAGE_EX_MEM = 3;
    localparam int STAGE_MEM_WB = 4;

    localparam int IF_ID_W  = 64;   // pc + inst
    localparam int ID_EX_W  = 81;   // aluop + alusel + reg1 + reg2 + wd + wreg
    localparam int EX_MEM_W = 103;  // wd + wreg + wdata + whilo + hi + lo
    localparam int MEM_WB_W = 103;

    localparam logic [IF_ID_W-1:0]  IF_ID_NOP  = '0;
    localparam logic [ID_EX_W-1:0]  ID_EX_NOP  = '0;
    localparam logic [EX_MEM_W-1:0] EX_MEM_NOP = '0;
    localparam logic [MEM_WB_W-1:0] MEM_WB_NOP = '0;

    typedef enum logic [1:0] {
        ACT_ADVANCE,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_FLUSH
    } stage_action_e;

    // Flush beats any stall pattern; a stopped stage whose successor runs emits a bubble.
    function automatic stage_action_e decode_action(input logic flush,
                                                    input logic stop_self,
                                                    input logic stop_next);
        if (flush)
            return ACT_FLUSH;
        if (stop_self == STOP)
            return (stop_next == STOP) ? ACT_HOLD : ACT_BUBBLE;
        return ACT_ADVANCE;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; never wraps.
module sat_counter
    import pipe_stage_reg_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    // NOTE: reset is sampled on the clock edge only, so it sits inside the edge-triggered block.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || clr)
            count_q <= '0;
        else if (inc && count_q != '1)
            count_q <= count_q + 1'b1;
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline register with stall/bubble/flush handling and
// saturating performance counters for hold, bubble and flush cycles.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                   PAYLOAD_W = MEM_WB_W,
    parameter int                   STAGE     = STAGE_MEM_WB,
    parameter int                   STALL_W   = STALL_VEC_W,
    parameter logic [PAYLOAD_W-1:0] NOP_VALUE = '0,
    parameter int                   CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_W-1:0]   stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_data,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    generate
        if (STAGE < 0 || STAGE >= STALL_W || PAYLOAD_W < 1 || CNT_W < 1) begin : g_param_err
            $fatal(1, "pipe_stage_reg: illegal parameters STAGE=%0d STALL_W=%0d PAYLOAD_W=%0d CNT_W=%0d",
                   STAGE, STALL_W, PAYLOAD_W, CNT_W);
        end
    endgenerate

    logic stop_self;
    logic stop_next;
    logic unused_stall;

    assign stop_self    = stall[STAGE];
    assign unused_stall = ^stall;

    // The last stage has no successor, so a stop there always turns into a bubble.
    generate
        if (STAGE < STALL_W - 1) begin : g_has_next
            assign stop_next = stall[STAGE+1];
        end else begin : g_last
            assign stop_next = NO_STOP;
        end
    endgenerate

    stage_action_e action;
    assign action = decode_action(flush, stop_self, stop_next);

    logic                 valid_d, valid_q;
    logic [PAYLOAD_W-1:0] data_d,  data_q;

    // NOTE: defaults first so every path assigns the next state and no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        unique case (action)
            ACT_FLUSH, ACT_BUBBLE: begin
                valid_d = 1'b0;
                data_d  = NOP_VALUE;
            end
            ACT_HOLD: ;
            ACT_ADVANCE: begin
                valid_d = in_valid;
                data_d  = in_valid ? in_data : NOP_VALUE;
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            valid_q <= 1'b0;
            data_q  <= NOP_VALUE;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (action == ACT_HOLD),
        .count(stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (action == ACT_BUBBLE),
        .count(bubble_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (action == ACT_FLUSH),
        .count(flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a default MEM/WB instance, a 3-bit counter
// instance for saturation, and a last-stage instance with a non-zero NOP payload.
module tb_pipe_stage_reg;

    localparam int PW = 103;
    localparam logic [PW-1:0] NOP_Z = '0;
    localparam logic [PW-1:0] NOP_L = 103'h1_2345_6789_ABCD_EF01_2345_6789;
    localparam logic [PW-1:0] D5A   = 103'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5;
    localparam logic [PW-1:0] X1    = 103'h0_1111_2222_3333_4444_5555_6666;
    localparam logic [PW-1:0] X2    = 103'h7_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
    localparam logic [PW-1:0] X3    = 103'h3_0BAD_F00D_0BAD_F00D_0BAD_F00D;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    stall;
    logic          flush;
    logic          in_valid;
    logic [PW-1:0] in_data;
    logic          cnt_clr;

    logic          out_valid_m, out_valid_s, out_valid_l;
    logic [PW-1:0] out_data_m,  out_data_s,  out_data_l;
    logic [15:0]   stall_cnt_m, bubble_cnt_m, flush_cnt_m;
    logic [2:0]    stall_cnt_s, bubble_cnt_s, flush_cnt_s;
    logic [15:0]   stall_cnt_l, bubble_cnt_l, flush_cnt_l;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.PAYLOAD_W(PW), .STAGE(4), .STALL_W(6), .NOP_VALUE(NOP_Z), .CNT_W(16)) dut_m (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid_m), .out_data(out_data_m), .cnt_clr(cnt_clr),
        .stall_cnt(stall_cnt_m), .bubble_cnt(bubble_cnt_m), .flush_cnt(flush_cnt_m)
    );

    pipe_stage_reg #(.PAYLOAD_W(PW), .STAGE(4), .STALL_W(6), .NOP_VALUE(NOP_Z), .CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid_s), .out_data(out_data_s), .cnt_clr(cnt_clr),
        .stall_cnt(stall_cnt_s), .bubble_cnt(bubble_cnt_s), .flush_cnt(flush_cnt_s)
    );

    pipe_stage_reg #(.PAYLOAD_W(PW), .STAGE(5), .STALL_W(6), .NOP_VALUE(NOP_L), .CNT_W(16)) dut_l (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid_l), .out_data(out_data_l), .cnt_clr(cnt_clr),
        .stall_cnt(stall_cnt_l), .bubble_cnt(bubble_cnt_l), .flush_cnt(flush_cnt_l)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_d(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_n(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_m_cnt(input string tag, input int s, input int b, input int f);
        check_n({tag, "_stall_cnt"},  32'(stall_cnt_m),  32'(s));
        check_n({tag, "_bubble_cnt"}, 32'(bubble_cnt_m), 32'(b));
        check_n({tag, "_flush_cnt"},  32'(flush_cnt_m),  32'(f));
    endtask

    initial begin
        rst = 1'b1; stall = 6'b000000; flush = 1'b0; cnt_clr = 1'b0;
        in_valid = 1'b1; in_data = D5A;

        // Reset held two cycles with a valid entry on the input.
        step(); step();
        check_b("rst_valid", out_valid_m, 1'b0);
        check_d("rst_data", out_data_m, NOP_Z);
        check_m_cnt("rst", 0, 0, 0);
        check_b("rst_valid_l", out_valid_l, 1'b0);
        check_d("rst_data_l", out_data_l, NOP_L);
        check_n("rst_stall_cnt_s", 32'(stall_cnt_s), 32'd0);

        // Advance: one-cycle latency, invalid payloads are replaced by the NOP.
        rst = 1'b0; in_valid = 1'b1; in_data = X1;
        step();
        check_b("adv1_valid", out_valid_m, 1'b1);
        check_d("adv1_data", out_data_m, X1);
        in_data = X2;
        step();
        check_d("adv2_data", out_data_m, X2);
        in_valid = 1'b0; in_data = X3;
        step();
        check_b("adv_inv_valid", out_valid_m, 1'b0);
        check_d("adv_inv_data", out_data_m, NOP_Z);

        // Hold three cycles, then bubble.
        in_valid = 1'b1; in_data = X1;
        step();
        stall = 6'b110000; in_data = X2;
        step(); step(); step();
        check_b("hold_valid", out_valid_m, 1'b1);
        check_d("hold_data", out_data_m, X1);
        check_m_cnt("hold", 3, 0, 0);
        stall = 6'b010000;
        step();
        check_b("bubble_valid", out_valid_m, 1'b0);
        check_d("bubble_data", out_data_m, NOP_Z);
        check_m_cnt("bubble", 3, 1, 0);

        // Flush wins over a hold while a valid entry is held.
        stall = 6'b000000; in_data = X2;
        step();
        stall = 6'b110000;
        step();
        check_d("pre_flush_data", out_data_m, X2);
        check_m_cnt("pre_flush", 4, 1, 0);
        flush = 1'b1;
        step();
        check_b("flush_valid", out_valid_m, 1'b0);
        check_d("flush_data", out_data_m, NOP_Z);
        check_m_cnt("flush", 4, 1, 1);

        // stop_self=0 with stop_next=1 still advances.
        flush = 1'b0; stall = 6'b100000; in_data = X1;
        step();
        check_b("adv_nextstop_valid", out_valid_m, 1'b1);
        check_d("adv_nextstop_data", out_data_m, X1);
        check_m_cnt("adv_nextstop", 4, 1, 1);

        // Flush counts every cycle, empty stage or not.
        stall = 6'b000000; flush = 1'b1;
        step(); step();
        check_b("flush2_valid", out_valid_m, 1'b0);
        check_m_cnt("flush2", 4, 1, 3);

        // Clear during a hold drops the event and leaves the payload alone.
        flush = 1'b0; in_data = X2;
        step();
        stall = 6'b110000; cnt_clr = 1'b1;
        step();
        check_b("clr_valid", out_valid_m, 1'b1);
        check_d("clr_data", out_data_m, X2);
        check_m_cnt("clr", 0, 0, 0);
        cnt_clr = 1'b0;
        step();
        check_m_cnt("post_clr", 1, 0, 0);

        // Reset during a hold discards the held entry.
        rst = 1'b1;
        step();
        check_b("rst_hold_valid", out_valid_m, 1'b0);
        check_d("rst_hold_data", out_data_m, NOP_Z);
        check_n("rst_hold_stall_cnt", 32'(stall_cnt_m), 32'd0);

        // Saturation of the 3-bit counters, then clear and restart.
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check_n("sat_stall_cnt_s", 32'(stall_cnt_s), 32'd7);
        check_n("sat_stall_cnt_m", 32'(stall_cnt_m), 32'd10);
        cnt_clr = 1'b1;
        step();
        check_n("sat_clr_stall_cnt_s", 32'(stall_cnt_s), 32'd0);
        cnt_clr = 1'b0;
        step();
        check_n("sat_restart_stall_cnt_s", 32'(stall_cnt_s), 32'd1);

        // Last stage: no successor, so any stop is a bubble.
        rst = 1'b1; stall = 6'b000000;
        step();
        rst = 1'b0; in_valid = 1'b1; in_data = X1;
        step();
        check_b("last_load_valid", out_valid_l, 1'b1);
        check_d("last_load_data", out_data_l, X1);
        stall = 6'b100000;
        step();
        check_b("last_bubble_valid", out_valid_l, 1'b0);
        check_d("last_bubble_data", out_data_l, NOP_L);
        check_n("last_bubble_cnt", 32'(bubble_cnt_l), 32'd1);
        check_n("last_stall_cnt", 32'(stall_cnt_l), 32'd0);
        check_d("last_m_adv_data", out_data_m, X1);
        stall = 6'b110000;
        step();
        check_n("last_bubble_cnt2", 32'(bubble_cnt_l), 32'd2);
        check_n("last_m_hold_cnt", 32'(stall_cnt_m), 32'd1);
        check_d("last_m_hold_data", out_data_m, X1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
